// File: rtl/hasti_bus_decoder.sv
// AHB-Lite (HASTI) single-master address decoder and data-phase response mux,
// with a built-in two-cycle ERROR default slave and an error counter that captures the address.
`timescale 1ns/1ps
module hasti_bus_decoder #(
    parameter int unsigned NUM_SLAVES    = 4,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDR_WIDTH-1:0]            haddr,
    input  logic [1:0]                       htrans,
    output logic                             hready,
    output logic [DATA_WIDTH-1:0]            hrdata,
    output logic                             hresp,
    output logic [NUM_SLAVES-1:0]            s_hsel,
    output logic                             s_hready,
    input  logic [NUM_SLAVES-1:0]            s_hreadyout,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hrdata,
    input  logic [NUM_SLAVES-1:0]            s_hresp,
    input  logic                             err_clear,
    output logic [ERR_CNT_WIDTH-1:0]         err_count,
    output logic [ADDR_WIDTH-1:0]            err_addr,
    output logic                             err_valid
);

    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_e;

    // Address-phase decode
    logic                  dec_hit;
    logic [SEL_W-1:0]      dec_idx;
    logic [NUM_SLAVES-1:0] hsel_d;

    // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        hsel_d  = '0;
        // Scan from the top down so the lowest matching index is the last one written.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((haddr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                dec_hit   = 1'b1;
                dec_idx   = SEL_W'(i);
                hsel_d    = '0;
                hsel_d[i] = 1'b1;
            end
        end
    end

    assign s_hsel = hsel_d;

    // Data-phase state
    logic                     dsel_hit_q;
    logic [SEL_W-1:0]         dsel_idx_q;
    ds_state_e                state_q, state_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q;
    logic [ADDR_WIDTH-1:0]    err_addr_q;
    logic                     err_valid_q;

    logic                  slv_ready;
    logic                  slv_resp;
    logic [DATA_WIDTH-1:0] slv_rdata;

    always_comb begin
        slv_ready = 1'b1;
        slv_resp  = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel_idx_q == SEL_W'(i)) begin
                slv_ready = s_hreadyout[i];
                slv_resp  = s_hresp[i];
                slv_rdata = s_hrdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign hready   = dsel_hit_q ? slv_ready : (state_q != DS_ERR1);
    assign hresp    = dsel_hit_q ? slv_resp  : (state_q != DS_IDLE);
    assign hrdata   = dsel_hit_q ? slv_rdata : '0;
    assign s_hready = hready;

    // An unmapped NONSEQ/SEQ is only accepted when the bus is ready.
    logic err_start;
    logic err_event;

    assign err_start = hready & ~dec_hit & htrans[1];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DS_IDLE: if (err_start) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = err_start ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
    end

    assign err_event = (state_d == DS_ERR1) && (state_q != DS_ERR1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            dsel_hit_q  <= 1'b0;
            dsel_idx_q  <= '0;
            state_q     <= DS_IDLE;
            err_count_q <= '0;
            err_addr_q  <= '0;
            err_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // A stalled data phase keeps its selection; the pending address phase waits.
            if (hready) begin
                dsel_hit_q <= dec_hit;
                dsel_idx_q <= dec_idx;
            end
            if (err_clear) begin
                err_count_q <= '0;
                err_valid_q <= 1'b0;
            end else if (err_event) begin
                err_addr_q  <= haddr;
                err_valid_q <= 1'b1;
                if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
            end
        end
    end

    assign err_count = err_count_q;
    assign err_addr  = err_addr_q;
    assign err_valid = err_valid_q;

    // htrans[0] (SEQ vs NONSEQ, IDLE vs BUSY) does not affect decoding.
    logic unused_htrans;
    assign unused_htrans = htrans[0];

endmodule

// File: tb/tb_hasti_bus_decoder.sv
// Directed bench for hasti_bus_decoder: the driver queues the expected per-cycle
// master-side response and a negedge monitor pops and compares it.
`timescale 1ns/1ps
module tb_hasti_bus_decoder;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 2;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_BUSY = 2'd1;
    localparam logic [1:0] T_NSEQ = 2'd2;
    localparam logic [1:0] T_SEQ  = 2'd3;

    localparam logic [31:0] UNM = 32'h3000_0000;
    localparam logic [31:0] D0  = 32'hAAAA_0000;
    localparam logic [31:0] D1  = 32'h1111_1111;
    localparam logic [31:0] D2  = 32'h2222_2222;
    localparam logic [31:0] D3  = 32'h3333_3333;

    logic               clk = 1'b0;
    logic               reset;
    logic [AW-1:0]      haddr;
    logic [1:0]         htrans;
    logic               hready;
    logic [DW-1:0]      hrdata;
    logic               hresp;
    logic [NS-1:0]      s_hsel;
    logic               s_hready;
    logic [NS-1:0]      s_hreadyout;
    logic [NS*DW-1:0]   s_hrdata;
    logic [NS-1:0]      s_hresp;
    logic               err_clear;
    logic [CW-1:0]      err_count;
    logic [AW-1:0]      err_addr;
    logic               err_valid;

    always #5 clk = ~clk;

    assign s_hrdata = {D3, D2, D1, D0};

    hasti_bus_decoder #(
        .NUM_SLAVES    (NS),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .SLAVE_BASE    ({32'h2000_0000, 32'h0000_0100, 32'h1000_0000, 32'h0000_0000}),
        .SLAVE_MASK    ({32'hF000_0000, 32'hFFFF_FF00, 32'hF000_0000, 32'hFFFF_F000}),
        .ERR_CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .haddr       (haddr),
        .htrans      (htrans),
        .hready      (hready),
        .hrdata      (hrdata),
        .hresp       (hresp),
        .s_hsel      (s_hsel),
        .s_hready    (s_hready),
        .s_hreadyout (s_hreadyout),
        .s_hrdata    (s_hrdata),
        .s_hresp     (s_hresp),
        .err_clear   (err_clear),
        .err_count   (err_count),
        .err_addr    (err_addr),
        .err_valid   (err_valid)
    );

    // bus = {hready, s_hready, hresp, s_hsel, hrdata}; err = {err_count, err_valid, err_addr}
    typedef struct {
        string       name;
        logic [38:0] bus;
        bit          chk_err;
        logic [34:0] err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic exp_t ex(input string n, input logic hr, input logic rs,
                                input logic [31:0] rd, input logic [3:0] sel);
        exp_t r;
        r.name    = n;
        r.bus     = {hr, hr, rs, sel, rd};
        r.chk_err = 1'b0;
        r.err     = '0;
        return r;
    endfunction

    function automatic exp_t exe(input string n, input logic hr, input logic rs,
                                 input logic [31:0] rd, input logic [3:0] sel,
                                 input logic [1:0] c, input logic v, input logic [31:0] ea);
        exp_t r;
        r         = ex(n, hr, rs, rd, sel);
        r.chk_err = 1'b1;
        r.err     = {c, v, ea};
        return r;
    endfunction

    function automatic logic [31:0] ua(input int k);
        return 32'h8000_0000 + 32'(k * 16);
    endfunction

    // Inputs change #1 after the edge; the expectation is for the cycle that follows.
    task automatic step(input logic [31:0] a, input logic [1:0] t, input exp_t e,
                        input logic [3:0] rdy = 4'hF, input logic [3:0] rsp = 4'h0,
                        input logic rst = 1'b0, input logic clr = 1'b0);
        @(posedge clk);
        #1;
        haddr       = a;
        htrans      = t;
        s_hreadyout = rdy;
        s_hresp     = rsp;
        reset       = rst;
        err_clear   = clr;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.name, "/bus"}, 64'({hready, s_hready, hresp, s_hsel, hrdata}), 64'(e.bus));
            if (e.chk_err)
                check({e.name, "/err"}, 64'({err_count, err_valid, err_addr}), 64'(e.err));
        end
    end

    initial begin
        haddr       = '0;
        htrans      = T_IDLE;
        s_hreadyout = 4'hF;
        s_hresp     = 4'h0;
        err_clear   = 1'b0;
        reset       = 1'b1;
        repeat (3) @(posedge clk);

        step(UNM, T_IDLE, exe("reset", 1, 0, 0, 4'b0000, 2'd0, 0, 32'h0));

        // Decode to slave 1, data returned in the following cycle
        step(32'h1000_0040, T_NSEQ, ex("t1_addr", 1, 0, 0, 4'b0010));
        step(UNM,           T_IDLE, ex("t1_data", 1, 0, D1, 4'b0000));

        // Slave 1 stalls three cycles; the slave-3 address phase waits
        step(32'h1000_0080, T_NSEQ, ex("t2_addr", 1, 0, 0, 4'b0010));
        for (int i = 0; i < 3; i++)
            step(32'h2000_0000, T_NSEQ, ex("t2_wait", 0, 0, D1, 4'b1000), 4'b1101);
        step(32'h2000_0000, T_NSEQ, ex("t2_release", 1, 0, D1, 4'b1000));
        step(UNM,           T_IDLE, ex("t2_next",    1, 0, D3, 4'b0000));

        // Single unmapped NONSEQ
        step(32'h8000_0000, T_NSEQ, ex("t3_addr", 1, 0, 0, 4'b0000));
        step(UNM, T_IDLE, exe("t3_err1", 0, 1, 0, 4'b0000, 2'd1, 1, 32'h8000_0000));
        step(UNM, T_IDLE, exe("t3_err2", 1, 1, 0, 4'b0000, 2'd1, 1, 32'h8000_0000));

        // Back-to-back unmapped NONSEQ then SEQ, then IDLE/BUSY to unmapped
        step(UNM, T_IDLE, ex("t4_clr", 1, 0, 0, 4'b0000), 4'hF, 4'h0, 1'b0, 1'b1);
        step(32'h8000_0010, T_NSEQ, exe("t4_a0",    1, 0, 0, 4'b0000, 2'd0, 0, 32'h8000_0000));
        step(32'h8000_0020, T_SEQ,  exe("t4_err1a", 0, 1, 0, 4'b0000, 2'd1, 1, 32'h8000_0010));
        step(32'h8000_0020, T_SEQ,  exe("t4_err2a", 1, 1, 0, 4'b0000, 2'd1, 1, 32'h8000_0010));
        step(32'h8000_0030, T_IDLE, exe("t4_err1b", 0, 1, 0, 4'b0000, 2'd2, 1, 32'h8000_0020));
        step(32'h8000_0030, T_IDLE, exe("t4_err2b", 1, 1, 0, 4'b0000, 2'd2, 1, 32'h8000_0020));
        step(32'h8000_0040, T_IDLE, exe("t4_idle",  1, 0, 0, 4'b0000, 2'd2, 1, 32'h8000_0020));
        step(32'h8000_0050, T_BUSY, exe("t4_busy",  1, 0, 0, 4'b0000, 2'd2, 1, 32'h8000_0020));
        step(UNM,           T_IDLE, exe("t4_nocnt", 1, 0, 0, 4'b0000, 2'd2, 1, 32'h8000_0020));

        // Overlapping slaves 0 and 2: lowest index wins; slave-0 ERROR passes through
        step(32'h0000_0100, T_NSEQ, ex("t5_overlap", 1, 0, 0, 4'b0001));
        step(UNM, T_IDLE, ex("t5_data", 1, 1, D0, 4'b0000), 4'hF, 4'b0001);

        // Five errors saturate the 2-bit counter at 3
        step(UNM, T_IDLE, ex("t6_clr", 1, 0, 0, 4'b0000), 4'hF, 4'h0, 1'b0, 1'b1);
        step(ua(0), T_NSEQ, exe("t6_start", 1, 0, 0, 4'b0000, 2'd0, 0, 32'h8000_0020));
        for (int k = 0; k < 5; k++) begin
            logic [31:0] na;
            logic [1:0]  nt;
            int          c;
            na = (k < 4) ? ua(k + 1) : UNM;
            nt = (k < 4) ? T_NSEQ : T_IDLE;
            c  = (k + 1 > 3) ? 3 : k + 1;
            step(na, nt, exe("t6_err1", 0, 1, 0, 4'b0000, 2'(c), 1, ua(k)));
            step(na, nt, exe("t6_err2", 1, 1, 0, 4'b0000, 2'(c), 1, ua(k)));
        end

        // Clear wins over a same-cycle error event
        step(ua(5), T_NSEQ, exe("t6_clrpri", 1, 0, 0, 4'b0000, 2'd3, 1, ua(4)), 4'hF, 4'h0, 1'b0, 1'b1);
        step(UNM, T_IDLE, exe("t6_lost", 0, 1, 0, 4'b0000, 2'd0, 0, ua(4)));
        step(UNM, T_IDLE, ex("t6_lost_err2", 1, 1, 0, 4'b0000));

        // Reset during ERR1 returns straight to IDLE without an ERR2 cycle
        step(32'h8000_0100, T_NSEQ, ex("t6_pre_rst", 1, 0, 0, 4'b0000));
        step(UNM, T_IDLE, exe("t6_rst_err1", 0, 1, 0, 4'b0000, 2'd1, 1, 32'h8000_0100), 4'hF, 4'h0, 1'b1, 1'b0);
        step(UNM, T_IDLE, exe("t6_after_rst",  1, 0, 0, 4'b0000, 2'd0, 0, 32'h0));
        step(UNM, T_IDLE, exe("t6_after_rst2", 1, 0, 0, 4'b0000, 2'd0, 0, 32'h0));

        @(negedge clk);
        #1;
        check("sb_drain", 64'(sb.size()), 64'd0);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL watchdog: got timeout expected completion");
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

endmodule
